// File: rtl/pad_scan_pkg.sv
// Shared types for the pad-matrix scan controller: scan FSM states and the
// press/release event word carried through the event FIFO.
package pad_scan_pkg;
  localparam int ROWS = 8;
  localparam int COLS = 4;
  localparam int EV_W = 6;

  typedef enum logic [2:0] {IDLE, BLANK, SETTLE, SAMPLE, EMIT} scan_state_e;

  typedef struct packed {
    logic [2:0] row;
    logic [1:0] col;
    logic       press;
  } pad_ev_t;
endpackage

// File: rtl/pad_event_fifo.sv
// Event FIFO with valid/ready pop. Head word is read straight from the
// storage flops, so it holds steady while the consumer stalls.
module pad_event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 6
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wp, rp;
  logic [AW:0]             cnt;
  logic                    do_pop, do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rp];

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      mem <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp      <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/pad_scan_ctrl.sv
// Row-scan controller: drives the row decoder, debounces the 32 pads row by
// row and queues press/release events for the consumer.
module pad_scan_ctrl
  import pad_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int DEB_CNT    = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 En,
  output logic [2:0]           RowSel,
  output logic                 RowEn,
  input  logic [COLS-1:0]      Sense,
  output logic                 EvValid,
  input  logic                 EvReady,
  output logic [4:0]           EvCode,
  output logic                 EvPress,
  output logic [ROWS*COLS-1:0] PadState,
  output logic                 Overrun
);
  localparam int SW = $clog2(SETTLE_CYC);

  scan_state_e                    state, nstate;
  logic [2:0]                     row_q, row_sel_q;
  logic [SW-1:0]                  set_cnt;
  logic [1:0]                     col_q;
  logic [COLS-1:0]                chg_q, flip, mis;
  logic [COLS-1:0][2:0]           cnt_nx;
  logic [ROWS*COLS-1:0]           pad_q;
  logic [ROWS*COLS-1:0][2:0]      deb_q;
  logic                           overrun_q;
  logic                           set_done, ev_push, ev_full, ev_empty;
  pad_ev_t                        ev_in, ev_head;

  assign set_done = (set_cnt == SW'(SETTLE_CYC - 1));

  // Per-column debounce step for the pad of the row being sampled.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [4:0] idx;
    logic [2:0] inc;
    assign idx       = {row_q, 2'(c)};
    assign inc       = deb_q[idx] + 3'd1;
    assign mis[c]    = Sense[c] ^ pad_q[idx];
    assign flip[c]   = mis[c] & (inc == 3'(DEB_CNT));
    assign cnt_nx[c] = (mis[c] & ~flip[c]) ? inc : 3'd0;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (En) nstate = BLANK;
      BLANK:   nstate = En ? SETTLE : IDLE;
      SETTLE:  if (set_done) nstate = SAMPLE;
      SAMPLE:  nstate = EMIT;
      EMIT:    if (col_q == 2'd3) nstate = BLANK;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    RowEn   = 1'b0;
    ev_push = 1'b0;
    unique case (state)
      SETTLE, SAMPLE: RowEn = 1'b1;
      EMIT:           ev_push = chg_q[col_q];
      default:        ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      row_q     <= '0;
      row_sel_q <= '0;
      set_cnt   <= '0;
      col_q     <= '0;
      chg_q     <= '0;
      pad_q     <= '0;
      deb_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      unique case (state)
        // RowSel only moves on the way into SETTLE, so an idle scan keeps the last row
        BLANK: if (En) begin
          row_sel_q <= row_q;
          set_cnt   <= '0;
        end
        SETTLE: set_cnt <= set_cnt + 1'b1;
        SAMPLE: begin
          col_q <= '0;
          chg_q <= flip;
          for (int c = 0; c < COLS; c++) begin
            deb_q[{row_q, 2'(c)}] <= cnt_nx[c];
            pad_q[{row_q, 2'(c)}] <= pad_q[{row_q, 2'(c)}] ^ flip[c];
          end
        end
        EMIT: begin
          col_q <= col_q + 1'b1;
          if (col_q == 2'd3) row_q <= row_q + 3'd1;
        end
        default: ;
      endcase
      if (ev_push && ev_full && !(EvValid && EvReady)) overrun_q <= 1'b1;
    end
  end

  assign ev_in = '{row: row_q, col: col_q, press: pad_q[{row_q, col_q}]};

  pad_event_fifo #(.DEPTH(FIFO_DEPTH), .W(EV_W)) u_fifo (
    .gclk   (CLK),
    .grst_n (nRST),
    .push   (ev_push),
    .wdata  (ev_in),
    .pop    (EvReady),
    .rdata  (ev_head),
    .full   (ev_full),
    .empty  (ev_empty)
  );

  assign RowSel   = row_sel_q;
  assign EvValid  = ~ev_empty;
  assign EvCode   = {ev_head.row, ev_head.col};
  assign EvPress  = ev_head.press;
  assign PadState = pad_q;
  assign Overrun  = overrun_q;
endmodule
